// File: rtl/fan_auto_stage_sel.sv
// fan_auto_stage_sel: turns validated DHT11 temperature/humidity samples into
// a 0-3 fan stage for the speed controller's stage_auto input. Temperature
// thresholds with hysteresis pick a target stage, a consecutive-sample filter
// confirms it before the base stage moves, humidity adds an unfiltered +1
// boost, and a missing-sample watchdog forces a safe stage.
module fan_auto_stage_sel #(
  parameter int T1          = 26,
  parameter int T2          = 28,
  parameter int T3          = 30,
  parameter int T_HYST      = 1,
  parameter int H_ON        = 80,
  parameter int H_HYST      = 5,
  parameter int CONFIRM     = 3,
  parameter int T_MAX_VALID = 60,
  parameter int TIMEOUT_CYC = 500_000_000,
  parameter int FAULT_STAGE = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       auto_en,
  input  logic       sample_valid,
  input  logic [7:0] temp,
  input  logic [7:0] humid,
  output logic [2:0] stage_auto,
  output logic       stage_change,
  output logic       sensor_fault
);

  // Counter widths: the confirmation counter must hold CONFIRM, the watchdog
  // must hold TIMEOUT_CYC where it saturates.
  localparam int CONF_W = (CONFIRM < 2) ? 1 : $clog2(CONFIRM + 1);
  localparam int TO_W   = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_MAX    = TO_W'(TIMEOUT_CYC);
  localparam logic [1:0]      FAULT_STG = 2'(FAULT_STAGE);

  // State registers and their next-state values
  logic [1:0]        base_q,   base_d;
  logic              boost_q,  boost_d;
  logic [1:0]        cand_q,   cand_d;
  logic [CONF_W-1:0] conf_q,   conf_d;
  logic [TO_W-1:0]   to_q,     to_d;
  logic              fault_q,  fault_d;
  logic [2:0]        stage_q,  stage_d;
  logic              change_q, change_d;

  // Decoded sample information
  logic       accepted;
  logic [1:0] upCnt;
  logic [1:0] dnCnt;
  logic [1:0] tgt;
  int         tempVal;
  int         humidVal;

  // Qualify the incoming sample: auto mode on and temperature plausible
  always_comb begin
    tempVal  = int'(temp);
    humidVal = int'(humid);
    accepted = sample_valid && auto_en && (tempVal <= T_MAX_VALID);
  end

  // Count thresholds crossed going up and (with hysteresis) going down
  always_comb begin
    upCnt = 2'd0;
    dnCnt = 2'd0;
    if (tempVal >= T1)          upCnt = upCnt + 2'd1;
    if (tempVal >= T2)          upCnt = upCnt + 2'd1;
    if (tempVal >= T3)          upCnt = upCnt + 2'd1;
    if (tempVal >= T1 - T_HYST) dnCnt = dnCnt + 2'd1;
    if (tempVal >= T2 - T_HYST) dnCnt = dnCnt + 2'd1;
    if (tempVal >= T3 - T_HYST) dnCnt = dnCnt + 2'd1;
  end

  // Pick the target: rise only past a full threshold, fall only below the
  // hysteresis band, otherwise stay where the base stage is
  always_comb begin
    tgt = base_q;
    if (upCnt > base_q) begin
      tgt = upCnt;
    end else if (dnCnt < base_q) begin
      tgt = dnCnt;
    end
  end

  // Next-state for the filter, boost and watchdog
  always_comb begin
    int confNext;
    base_d   = base_q;
    boost_d  = boost_q;
    cand_d   = cand_q;
    conf_d   = conf_q;
    to_d     = to_q;
    fault_d  = fault_q;
    confNext = 0;

    if (!auto_en) begin
      base_d  = 2'd0;
      boost_d = 1'b0;
      cand_d  = 2'd0;
      conf_d  = '0;
      to_d    = '0;
      fault_d = 1'b0;
    end else if (accepted) begin
      to_d    = '0;
      fault_d = 1'b0;

      if (tgt == base_q) begin
        conf_d = '0;
      end else begin
        if (tgt != cand_q) begin
          cand_d   = tgt;
          confNext = 1;
        end else begin
          confNext = int'(conf_q) + 1;
        end
        if (confNext >= CONFIRM) begin
          base_d = tgt;
          conf_d = '0;
        end else begin
          conf_d = CONF_W'(confNext);
        end
      end

      if (humidVal >= H_ON) begin
        boost_d = 1'b1;
      end else if (humidVal < H_ON - H_HYST) begin
        boost_d = 1'b0;
      end
    end else begin
      if (to_q != TO_MAX) begin
        to_d = to_q + TO_W'(1);
      end
      if (to_d == TO_MAX) begin
        fault_d = 1'b1;
      end
    end
  end

  // Output stage from next-state so the registered output has latency 1
  always_comb begin
    logic [2:0] sum;
    sum      = {1'b0, base_d} + {2'b00, boost_d};
    stage_d  = 3'd0;
    if (!auto_en) begin
      stage_d = 3'd0;
    end else if (fault_d) begin
      stage_d = {1'b0, FAULT_STG};
    end else if (sum > 3'd3) begin
      stage_d = 3'd3;
    end else begin
      stage_d = sum;
    end
    change_d = (stage_d != stage_q);
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q   <= 2'd0;
      boost_q  <= 1'b0;
      cand_q   <= 2'd0;
      conf_q   <= '0;
      to_q     <= '0;
      fault_q  <= 1'b0;
      stage_q  <= 3'd0;
      change_q <= 1'b0;
    end else begin
      base_q   <= base_d;
      boost_q  <= boost_d;
      cand_q   <= cand_d;
      conf_q   <= conf_d;
      to_q     <= to_d;
      fault_q  <= fault_d;
      stage_q  <= stage_d;
      change_q <= change_d;
    end
  end

  assign stage_auto   = stage_q;
  assign stage_change = change_q;
  assign sensor_fault = fault_q;

endmodule

// File: tb/tb_fan_auto_stage_sel.sv
// tb_fan_auto_stage_sel: directed vectors with hand-computed expected stages
// for the automatic fan-stage selector (watchdog shortened to 100 cycles).
module tb_fan_auto_stage_sel;

  logic       clk;
  logic       reset_n;
  logic       auto_en;
  logic       sample_valid;
  logic [7:0] temp;
  logic [7:0] humid;
  logic [2:0] stage_auto;
  logic       stage_change;
  logic       sensor_fault;

  int total = 0;
  int bad = 0;
  int pulseCount = 0;
  int pulseBase = 0;

  fan_auto_stage_sel #(.TIMEOUT_CYC(100)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .auto_en      (auto_en),
    .sample_valid (sample_valid),
    .temp         (temp),
    .humid        (humid),
    .stage_auto   (stage_auto),
    .stage_change (stage_change),
    .sensor_fault (sensor_fault)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count stage_change pulses shortly after each rising edge
  always @(posedge clk) begin
    #2;
    if (stage_change === 1'b1) pulseCount++;
  end

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One-cycle sample strobe; returns at the falling edge after it was taken
  task automatic applyStimulus(input int t, input int h);
    @(negedge clk);
    sample_valid = 1'b1;
    temp         = 8'(t);
    humid        = 8'(h);
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    auto_en      = 1'b0;
    sample_valid = 1'b0;
    temp         = 8'd0;
    humid        = 8'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_stage", 32'(stage_auto), 0);
    checkOutput("reset_change", 32'(stage_change), 0);
    checkOutput("reset_fault", 32'(sensor_fault), 0);

    reset_n = 1'b1;
    auto_en = 1'b1;
    @(negedge clk);
    checkOutput("enable_stage", 32'(stage_auto), 0);

    // Stage up with confirmation
    pulseBase = pulseCount;
    applyStimulus(29, 50);
    checkOutput("up_s1", 32'(stage_auto), 0);
    applyStimulus(29, 50);
    checkOutput("up_s2", 32'(stage_auto), 0);
    applyStimulus(29, 50);
    checkOutput("up_s3", 32'(stage_auto), 2);
    checkOutput("up_pulse", 32'(stage_change), 1);
    @(negedge clk);
    checkOutput("up_pulse_end", 32'(stage_change), 0);
    checkOutput("up_pulse_count", 32'(pulseCount - pulseBase), 1);

    // Hysteresis: 27 is inside the band, 26 is below it
    for (int i = 0; i < 3; i++) applyStimulus(27, 50);
    checkOutput("hyst_27", 32'(stage_auto), 2);
    applyStimulus(26, 50);
    applyStimulus(27, 50);
    applyStimulus(26, 50);
    applyStimulus(27, 50);
    checkOutput("hyst_interleave", 32'(stage_auto), 2);
    applyStimulus(26, 50);
    applyStimulus(26, 50);
    checkOutput("hyst_26_two", 32'(stage_auto), 2);
    applyStimulus(26, 50);
    checkOutput("hyst_26_three", 32'(stage_auto), 1);

    // Humidity boost with its own hysteresis
    applyStimulus(26, 85);
    checkOutput("boost_on", 32'(stage_auto), 2);
    applyStimulus(26, 78);
    checkOutput("boost_hold", 32'(stage_auto), 2);
    applyStimulus(26, 74);
    checkOutput("boost_off", 32'(stage_auto), 1);

    // Cap at 3 while boosted and jumping straight from 1 to 3
    applyStimulus(35, 90);
    checkOutput("cap_s1", 32'(stage_auto), 2);
    applyStimulus(35, 90);
    applyStimulus(35, 90);
    checkOutput("cap_s3", 32'(stage_auto), 3);
    checkOutput("cap_bit2", 32'(stage_auto[2]), 0);
    applyStimulus(70, 10);
    checkOutput("invalid_temp", 32'(stage_auto), 3);

    // Back down to stage 1 without boost
    for (int i = 0; i < 3; i++) applyStimulus(26, 50);
    checkOutput("down_to_1", 32'(stage_auto), 1);

    // Watchdog: an out-of-range sample midway must not restart it
    pulseBase = pulseCount;
    for (int i = 1; i < 100; i++) begin
      @(negedge clk);
      sample_valid = (i == 50);
      temp         = 8'd70;
      humid        = 8'd50;
    end
    checkOutput("fault_pre", 32'(sensor_fault), 0);
    checkOutput("fault_pre_stage", 32'(stage_auto), 1);
    @(negedge clk);
    checkOutput("fault_set", 32'(sensor_fault), 1);
    checkOutput("fault_stage", 32'(stage_auto), 2);
    checkOutput("fault_pulse", 32'(stage_change), 1);
    checkOutput("fault_pulse_count", 32'(pulseCount - pulseBase), 1);
    applyStimulus(20, 50);
    checkOutput("fault_clear", 32'(sensor_fault), 0);
    checkOutput("fault_clear_stage", 32'(stage_auto), 1);
    checkOutput("fault_clear_pulse", 32'(stage_change), 1);

    // Climb to 3, then drop auto_en with a sample in the same cycle
    for (int i = 0; i < 3; i++) applyStimulus(35, 50);
    checkOutput("climb_3", 32'(stage_auto), 3);
    @(negedge clk);
    auto_en      = 1'b0;
    sample_valid = 1'b1;
    temp         = 8'd35;
    @(negedge clk);
    sample_valid = 1'b0;
    checkOutput("disable_stage", 32'(stage_auto), 0);
    checkOutput("disable_pulse", 32'(stage_change), 1);
    auto_en = 1'b1;
    @(negedge clk);
    checkOutput("reenable_stage", 32'(stage_auto), 0);
    applyStimulus(35, 50);
    checkOutput("reenable_s1", 32'(stage_auto), 0);
    applyStimulus(35, 50);
    checkOutput("reenable_s2", 32'(stage_auto), 0);

    // Reset mid-confirmation discards the partial count
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_stage", 32'(stage_auto), 0);
    checkOutput("midreset_fault", 32'(sensor_fault), 0);
    reset_n = 1'b1;
    applyStimulus(35, 50);
    checkOutput("post_reset_s1", 32'(stage_auto), 0);
    applyStimulus(35, 50);
    applyStimulus(35, 50);
    checkOutput("post_reset_s3", 32'(stage_auto), 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
